// File: rtl/cmp_pkg.sv
// Shared types for the nibble-serial comparator: sequencer states and the
// one-hot result encoding, ordered {lt, gt, eq}.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [2:0] RES_LT = 3'b100;
  localparam logic [2:0] RES_GT = 3'b010;
  localparam logic [2:0] RES_EQ = 3'b001;

endpackage

// File: rtl/comparator_4bit.sv
// Unsigned 4-bit magnitude comparator; the single shared datapath element
// that the sequencer steps across the operand nibbles.
module comparator_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       l,
  output logic       g,
  output logic       e
);

  assign l = (a <  b);
  assign g = (a >  b);
  assign e = (a == b);

endmodule

// File: rtl/wide_cmp_sequencer.sv
// Wide unsigned compare built from one 4-bit comparator, scanning nibbles
// MSB first, with valid/ready handshakes on operands and result.
module wide_cmp_sequencer
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NIB - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             lt_s_q, lt_s_d, gt_s_q, gt_s_d;
  logic [2:0]       res_q, res_d;

  logic [3:0] nib_a, nib_b;
  logic       cmp_l, cmp_g, cmp_e;
  logic       undecided, new_lt, new_gt;

  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  comparator_4bit u_cmp (
    .a (nib_a),
    .b (nib_b),
    .l (cmp_l),
    .g (cmp_g),
    .e (cmp_e)
  );

  // Sticky decision: the first unequal nibble fixes the answer for the rest of the scan.
  assign undecided = ~lt_s_q & ~gt_s_q;
  assign new_lt    = lt_s_q | (undecided & ~cmp_e & cmp_l);
  assign new_gt    = gt_s_q | (undecided & ~cmp_e & cmp_g);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    lt_s_d  = lt_s_q;
    gt_s_d  = gt_s_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_TOP;
          lt_s_d  = 1'b0;
          gt_s_d  = 1'b0;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        lt_s_d = new_lt;
        gt_s_d = new_gt;
        if ((EARLY_EXIT && (new_lt || new_gt)) || (idx_q == '0)) begin
          res_d   = new_lt ? RES_LT : (new_gt ? RES_GT : RES_EQ);
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          res_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        res_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      lt_s_q  <= 1'b0;
      gt_s_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      lt_s_q  <= lt_s_d;
      gt_s_q  <= gt_s_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == COMPARE);
  assign out_valid = (state_q == DONE);
  assign lt        = res_q[2];
  assign gt        = res_q[1];
  assign eq        = res_q[0];

endmodule
